// File: rtl/dmux8_dispatcher_pkg.sv
// Shared constants and state encoding for the 8-way dispatcher.
package dmux8_dispatcher_pkg;

  localparam int N_DST = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } disp_state_e;

endpackage

// File: rtl/dmux8_dispatcher_rr_pick8.sv
// Rotating priority encoder: first set mask bit at or after start, wrapping mod 8.
module rr_pick8
  import dmux8_dispatcher_pkg::*;
(
  input  logic [N_DST-1:0] mask,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  // Walk offsets from farthest to nearest so the nearest eligible bit wins.
  always_comb begin
    logic [SEL_W-1:0] cand;
    idx  = start;
    cand = start;
    any  = |mask;
    for (int i = N_DST - 1; i >= 0; i--) begin
      cand = start + SEL_W'(i);
      if (mask[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/dmux8_dispatcher.sv
// Dispatcher sharing one beat stream among 8 destinations, one held beat at a time.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_EMPTY | output register free, may accept a beat
//   ST_FULL  | a beat is held for destination cur_sel_q
module dmux8_dispatcher
  import dmux8_dispatcher_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [N_DST-1:0] en_mask,
  output logic [N_DST-1:0] out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic [N_DST-1:0] dst_ready,
  output logic [SEL_W-1:0] rr_ptr,
  output logic             busy
);

  disp_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N_DST-1:0] out_valid_q, out_valid_d;

  logic [SEL_W-1:0] rr_idx;
  logic             rr_any;
  logic [SEL_W-1:0] pick;
  logic             pick_ok;
  logic             deliver;
  logic             accept;

  rr_pick8 u_rr_pick8 (
    .mask  (en_mask),
    .start (rr_ptr_q),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  // Next-state, handshake and register-load decisions.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    cur_sel_d   = cur_sel_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;

    pick     = in_dir ? in_sel : rr_idx;
    pick_ok  = in_dir | rr_any;
    deliver  = (state_q == ST_FULL) && dst_ready[cur_sel_q];
    in_ready = reset_n && pick_ok && ((state_q == ST_EMPTY) || deliver);
    accept   = in_valid && in_ready;

    if (accept) begin
      // Covers the back-to-back case: a delivering beat is replaced in place.
      state_d     = ST_FULL;
      data_d      = in_data;
      cur_sel_d   = pick;
      out_valid_d = N_DST'(1) << pick;
      if (!in_dir) rr_ptr_d = pick + SEL_W'(1);
    end else if (deliver) begin
      state_d     = ST_EMPTY;
      out_valid_d = '0;
    end
  end

  // State and datapath registers; reset discards any held beat at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_EMPTY;
      data_q      <= '0;
      cur_sel_q   <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      cur_sel_q   <= cur_sel_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign rr_ptr    = rr_ptr_q;
  assign busy      = (state_q == ST_FULL);

endmodule
